// File: rtl/mm1_dmem_req.sv
// MM1 data-memory request unit: issues one SRAM-like request per memory
// instruction, stalls MM1 until the address is accepted, buffers early read
// data and counts flushed requests so their stale data_ok can be dropped.
module mm1_dmem_req (
  input  logic        clk,
  input  logic        rst,
  input  logic        mm1_valid,
  input  logic        mm1_mm_re,
  input  logic        mm1_mm_we,
  input  logic [1:0]  mm1_mm_access_sz,
  input  logic [31:0] mm1_mm_addr,
  input  logic [31:0] mm1_mm_wdata,
  input  logic        mm1_except,
  input  logic        flush,
  input  logic        mm2_allowin,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        mm1_stall,
  output logic        mm1_mem_issued,
  output logic        mm1_early_valid,
  output logic [31:0] mm1_early_rdata,
  output logic        drop_data_ok
);

  typedef enum logic [1:0] {IDLE, WAIT_AOK, ACCEPTED, CANCEL_WAIT} state_t;

  state_t      state, state_n;
  logic [1:0]  cnt;
  logic        need, issue_new, cnt_inc, cnt_dec, capture;
  logic [3:0]  enc_wstrb;
  logic [31:0] enc_wdata;
  logic        h_wr;
  logic [1:0]  h_size;
  logic [31:0] h_addr;
  logic [3:0]  h_wstrb;
  logic [31:0] h_wdata;

  assign need      = mm1_valid & (mm1_mm_re | mm1_mm_we) & ~mm1_except;
  assign issue_new = (state == IDLE) & need & ~flush & (cnt != 2'd3) & ~rst;
  assign cnt_dec   = data_sram_data_ok & (cnt != 2'd0);

  // Byte-lane strobes and replicated store data for the MM1 access.
  always_comb begin
    enc_wstrb = 4'b1111;
    enc_wdata = mm1_mm_wdata;
    case (mm1_mm_access_sz)
      2'b00: begin
        enc_wstrb = 4'b0001 << mm1_mm_addr[1:0];
        enc_wdata = {4{mm1_mm_wdata[7:0]}};
      end
      2'b01: begin
        enc_wstrb = 4'b0011 << {mm1_mm_addr[1], 1'b0};
        enc_wdata = {2{mm1_mm_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!mm1_mm_we) enc_wstrb = '0;
  end

  // Next-state, request and issue decode.
  always_comb begin
    state_n        = state;
    data_sram_req  = 1'b0;
    mm1_mem_issued = 1'b0;
    cnt_inc        = 1'b0;
    capture        = 1'b0;
    case (state)
      IDLE: begin
        if (issue_new) begin
          data_sram_req = 1'b1;
          if (data_sram_addr_ok) begin
            if (mm2_allowin) mm1_mem_issued = 1'b1;
            else             state_n = ACCEPTED;
          end else begin
            state_n = WAIT_AOK;
          end
        end
      end
      WAIT_AOK: begin
        data_sram_req = 1'b1;
        if (data_sram_addr_ok) begin
          if (flush) begin
            cnt_inc = 1'b1;
            state_n = IDLE;
          end else if (mm2_allowin) begin
            mm1_mem_issued = 1'b1;
            state_n        = IDLE;
          end else begin
            state_n = ACCEPTED;
          end
        end else if (flush) begin
          state_n = CANCEL_WAIT;
        end
      end
      CANCEL_WAIT: begin
        data_sram_req = 1'b1;
        if (data_sram_addr_ok) begin
          cnt_inc = 1'b1;
          state_n = IDLE;
        end
      end
      ACCEPTED: begin
        capture = data_sram_data_ok & (cnt == 2'd0);
        if (flush) begin
          cnt_inc = ~(mm1_early_valid | capture);
          state_n = IDLE;
        end else if (mm2_allowin) begin
          mm1_mem_issued = 1'b1;
          state_n        = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // addr_ok for a cancelled request does not release the new MM1 instruction.
  assign mm1_stall = need & ~flush &
                     ~((state == ACCEPTED) |
                       (data_sram_req & data_sram_addr_ok & (state != CANCEL_WAIT)));

  assign drop_data_ok = cnt_dec;

  assign data_sram_wr    = (state == IDLE) ? mm1_mm_we        : h_wr;
  assign data_sram_size  = (state == IDLE) ? mm1_mm_access_sz : h_size;
  assign data_sram_addr  = (state == IDLE) ? mm1_mm_addr      : h_addr;
  assign data_sram_wstrb = (state == IDLE) ? enc_wstrb        : h_wstrb;
  assign data_sram_wdata = (state == IDLE) ? enc_wdata        : h_wdata;

  // State register and cancel counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      case ({cnt_inc, cnt_dec})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Hold registers keep the request fields stable until addr_ok.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_wr    <= 1'b0;
      h_size  <= '0;
      h_addr  <= '0;
      h_wstrb <= '0;
      h_wdata <= '0;
    end else if (issue_new) begin
      h_wr    <= mm1_mm_we;
      h_size  <= mm1_mm_access_sz;
      h_addr  <= mm1_mm_addr;
      h_wstrb <= enc_wstrb;
      h_wdata <= enc_wdata;
    end
  end

  // Early read-data buffer, valid until the instruction leaves MM1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mm1_early_valid <= 1'b0;
      mm1_early_rdata <= '0;
    end else if (state_n != ACCEPTED) begin
      mm1_early_valid <= 1'b0;
    end else if (capture) begin
      mm1_early_valid <= 1'b1;
      mm1_early_rdata <= data_sram_rdata;
    end
  end

endmodule
